// File: rtl/spi_adc_pkg.sv
// Shared types and constants for the MCP3002-style SPI ADC responder.
package spi_adc_pkg;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      WAIT_START = 3'd1,
      CONFIG     = 3'd2,
      NULL       = 3'd3,
      DATA       = 3'd4,
      DONE       = 3'd5
   } state_t;

   localparam int DATA_W_DEF = 10;
   localparam int CFG_BITS   = 3;

endpackage

// File: rtl/spi_adc_responder_sync.sv
// Oversampling synchronizer for one asynchronous SPI pin, with a history flop
// so rising and falling edges can be detected in the sysclk domain.
module spi_pin_sync #(
   parameter int   SYNC_STAGES = 2,
   parameter logic RST_VAL     = 1'b0
) (
   input  logic sysclk,
   input  logic rst_n,
   input  logic i_pin,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_hist;

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync <= {SYNC_STAGES{RST_VAL}};
         r_hist <= RST_VAL;
      end else begin
         r_sync <= SYNC_STAGES'({r_sync, i_pin});
         r_hist <= r_sync[SYNC_STAGES-1];
      end
   end

   assign o_level = r_sync[SYNC_STAGES-1];
   assign o_rise  = o_level & ~r_hist;
   assign o_fall  = ~o_level & r_hist;

endmodule

// File: rtl/spi_adc_responder.sv
// SPI responder emulating an MCP3002: decodes start/SGL/ODD/MSBF from MOSI and
// shifts a null bit plus a DATA_W-bit sample out on MISO, MSB first.
//
// state      | meaning
// IDLE       | chip select high, MISO released
// WAIT_START | CS low, skipping leading zeros until the start bit
// CONFIG     | capturing SGL, ODD, MSBF on SCK rises
// NULL       | next SCK fall latches the sample and drives the null bit
// DATA       | SCK falls shift the sample out MSB first
// DONE       | sample sent; extra SCK falls drive 0 until CS rises
module spi_adc_responder
   import spi_adc_pkg::*;
#(
   parameter int DATA_W      = DATA_W_DEF,
   parameter int SYNC_STAGES = 2
) (
   input  logic              sysclk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] ch0_data,
   input  logic [DATA_W-1:0] ch1_data,
   input  logic              adc_cs,
   input  logic              adc_sck,
   input  logic              sdata_to_adc,
   output logic              sdata_from_adc,
   output logic              sdo_oe,
   output logic              sample_strobe,
   output logic              sampled_ch,
   output logic              frame_err
);

   localparam int CNT_W = ($clog2(DATA_W) < 2) ? 2 : $clog2(DATA_W);

   logic w_cs, w_sdi, w_sck_rise, w_sck_fall;
   logic w_sck_lvl_unused, w_cs_rise_unused, w_cs_fall_unused;
   logic w_sdi_rise_unused, w_sdi_fall_unused;

   // CS resets high so a released reset never looks like a fresh frame start.
   spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
      .sysclk(sysclk), .rst_n(rst_n), .i_pin(adc_cs),
      .o_level(w_cs), .o_rise(w_cs_rise_unused), .o_fall(w_cs_fall_unused)
   );

   spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
      .sysclk(sysclk), .rst_n(rst_n), .i_pin(adc_sck),
      .o_level(w_sck_lvl_unused), .o_rise(w_sck_rise), .o_fall(w_sck_fall)
   );

   spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sdi (
      .sysclk(sysclk), .rst_n(rst_n), .i_pin(sdata_to_adc),
      .o_level(w_sdi), .o_rise(w_sdi_rise_unused), .o_fall(w_sdi_fall_unused)
   );

   state_t              r_state, w_state_nxt;
   logic                r_sgl, w_sgl_nxt;
   logic                r_odd, w_odd_nxt;
   logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
   logic [DATA_W-1:0]   r_shift, w_shift_nxt;
   logic                r_sdo, w_sdo_nxt;
   logic                r_oe, w_oe_nxt;
   logic                r_ch, w_ch_nxt;
   logic                r_strobe, w_strobe_nxt;
   logic                r_ferr, w_ferr_nxt;

   // Pseudo-differential result is one bit wider so a negative difference can be clamped.
   logic [DATA_W-1:0]   w_pos, w_neg, w_sample;
   logic [DATA_W:0]     w_diff;

   assign w_pos    = r_odd ? ch1_data : ch0_data;
   assign w_neg    = r_odd ? ch0_data : ch1_data;
   assign w_diff   = {1'b0, w_pos} - {1'b0, w_neg};
   assign w_sample = r_sgl ? w_pos : (w_diff[DATA_W] ? '0 : w_diff[DATA_W-1:0]);

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_sgl    <= 1'b0;
         r_odd    <= 1'b0;
         r_cnt    <= '0;
         r_shift  <= '0;
         r_sdo    <= 1'b0;
         r_oe     <= 1'b0;
         r_ch     <= 1'b0;
         r_strobe <= 1'b0;
         r_ferr   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_sgl    <= w_sgl_nxt;
         r_odd    <= w_odd_nxt;
         r_cnt    <= w_cnt_nxt;
         r_shift  <= w_shift_nxt;
         r_sdo    <= w_sdo_nxt;
         r_oe     <= w_oe_nxt;
         r_ch     <= w_ch_nxt;
         r_strobe <= w_strobe_nxt;
         r_ferr   <= w_ferr_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_sgl_nxt    = r_sgl;
      w_odd_nxt    = r_odd;
      w_cnt_nxt    = r_cnt;
      w_shift_nxt  = r_shift;
      w_sdo_nxt    = r_sdo;
      w_oe_nxt     = r_oe;
      w_ch_nxt     = r_ch;
      w_strobe_nxt = 1'b0;
      w_ferr_nxt   = 1'b0;

      // CS high overrides any SCK edge seen in the same cycle.
      if (w_cs) begin
         w_state_nxt = IDLE;
         w_oe_nxt    = 1'b0;
         w_sdo_nxt   = 1'b0;
         if (r_state == CONFIG || r_state == NULL || r_state == DATA)
            w_ferr_nxt = 1'b1;
      end else begin
         unique case (r_state)
            IDLE: w_state_nxt = WAIT_START;
            WAIT_START: begin
               if (w_sck_rise && w_sdi) begin
                  w_state_nxt = CONFIG;
                  w_cnt_nxt   = CNT_W'(CFG_BITS - 1);
               end
            end
            CONFIG: begin
               if (w_sck_rise) begin
                  if (r_cnt == CNT_W'(CFG_BITS - 1)) w_sgl_nxt = w_sdi;
                  else if (r_cnt == CNT_W'(CFG_BITS - 2)) w_odd_nxt = w_sdi;
                  if (r_cnt == '0) w_state_nxt = NULL;
                  else             w_cnt_nxt   = r_cnt - 1'b1;
               end
            end
            NULL: begin
               if (w_sck_fall) begin
                  w_shift_nxt  = w_sample;
                  w_sdo_nxt    = 1'b0;
                  w_oe_nxt     = 1'b1;
                  w_strobe_nxt = 1'b1;
                  w_ch_nxt     = r_odd;
                  w_cnt_nxt    = CNT_W'(DATA_W - 1);
                  w_state_nxt  = DATA;
               end
            end
            DATA: begin
               if (w_sck_fall) begin
                  w_sdo_nxt   = r_shift[DATA_W-1];
                  w_shift_nxt = {r_shift[DATA_W-2:0], 1'b0};
                  if (r_cnt == '0) w_state_nxt = DONE;
                  else             w_cnt_nxt   = r_cnt - 1'b1;
               end
            end
            DONE: begin
               if (w_sck_fall) w_sdo_nxt = 1'b0;
            end
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   assign sdata_from_adc = r_sdo;
   assign sdo_oe         = r_oe;
   assign sample_strobe  = r_strobe;
   assign sampled_ch     = r_ch;
   assign frame_err      = r_ferr;

endmodule

// File: tb/tb_spi_adc_responder.sv
// Directed bench for spi_adc_responder: an SPI mode-0 initiator drives frames,
// a frame-level model predicts MISO/OE per SCK rise and the frame-level pulses.
module tb_spi_adc_responder;

   localparam int HALF = 160;

   logic       sysclk = 1'b0;
   logic       rst_n  = 1'b0;
   logic [9:0] ch0_data = '0;
   logic [9:0] ch1_data = '0;
   logic       adc_cs = 1'b1;
   logic       adc_sck = 1'b0;
   logic       sdata_to_adc = 1'b0;
   logic       sdata_from_adc, sdo_oe, sample_strobe, sampled_ch, frame_err;

   spi_adc_responder dut (
      .sysclk(sysclk), .rst_n(rst_n), .ch0_data(ch0_data), .ch1_data(ch1_data),
      .adc_cs(adc_cs), .adc_sck(adc_sck), .sdata_to_adc(sdata_to_adc),
      .sdata_from_adc(sdata_from_adc), .sdo_oe(sdo_oe),
      .sample_strobe(sample_strobe), .sampled_ch(sampled_ch), .frame_err(frame_err)
   );

   always #10 sysclk = ~sysclk;

   int tests = 0;
   int fails = 0;
   int exp_miso [64];
   int exp_oe   [64];
   int rx_bits  [64];
   int exp_strobe, exp_ferr, exp_ch;
   bit frame_active = 1'b0;
   int frame_id = 0;
   int seen_id  = 0;
   int ridx     = 0;
   int strobe_cnt = 0;
   int ferr_cnt   = 0;

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Expected MISO/OE at each SCK rise, derived from where the start bit sits.
   function automatic void build_model(input logic [31:0] m, input int n, input int last,
                                       input int c0, input int c1);
      int s;
      int sgl, odd, val;
      s = -1;
      for (int k = 1; k < 32; k++)
         if (s < 0 && k <= n && m[k]) s = k;
      for (int k = 0; k < 64; k++) begin
         exp_miso[k] = 0;
         exp_oe[k]   = 0;
      end
      exp_strobe = 0;
      exp_ferr   = 0;
      exp_ch     = 0;
      if (s < 0) return;
      sgl = int'(m[s+1]);
      odd = int'(m[s+2]);
      if (sgl != 0) val = (odd != 0) ? c1 : c0;
      else          val = (odd != 0) ? c1 - c0 : c0 - c1;
      if (val < 0) val = 0;
      for (int k = s + 4; k <= n; k++) begin
         exp_oe[k] = 1;
         if (k >= s + 5 && k <= s + 14) exp_miso[k] = (val >> (9 - (k - s - 5))) & 1;
      end
      exp_strobe = (last >= s + 3) ? 1 : 0;
      exp_ferr   = (last >= s && last <= s + 12) ? 1 : 0;
      exp_ch     = odd;
   endfunction

   always @(negedge sysclk) begin
      if (sample_strobe) strobe_cnt++;
      if (frame_err)     ferr_cnt++;
   end

   always @(posedge adc_sck) begin
      if (frame_active) begin
         if (frame_id != seen_id) begin
            seen_id = frame_id;
            ridx    = 0;
         end
         ridx++;
         rx_bits[ridx] = int'(sdata_from_adc);
         check($sformatf("miso f%0d r%0d", frame_id, ridx), int'(sdata_from_adc), exp_miso[ridx]);
         check($sformatf("oe f%0d r%0d", frame_id, ridx), int'(sdo_oe), exp_oe[ridx]);
      end
   end

   task automatic run_frame(input string name, input logic [31:0] m, input int n,
                            input int abort_k, input logic [9:0] c0, input logic [9:0] c1,
                            input int chg_k, input logic [9:0] chg_v,
                            input int dstart, input logic [9:0] lit);
      int s0, f0;
      logic [9:0] rx;
      ch0_data = c0;
      ch1_data = c1;
      build_model(m, n, (abort_k > 0) ? abort_k : n, int'(c0), int'(c1));
      s0 = strobe_cnt;
      f0 = ferr_cnt;
      frame_id++;
      frame_active = 1'b1;
      adc_cs = 1'b0;
      #HALF;
      for (int k = 1; k <= n; k++) begin
         sdata_to_adc = m[k];
         #HALF;
         adc_sck = 1'b1;
         #HALF;
         if (k == chg_k) ch0_data = chg_v;
         adc_sck = 1'b0;
         if (k == abort_k) begin
            #40;
            adc_cs = 1'b1;
            repeat (4) @(posedge sysclk);
            #1;
            check({name, " abort oe"}, int'(sdo_oe), 0);
            break;
         end
      end
      sdata_to_adc = 1'b0;
      #HALF;
      adc_cs = 1'b1;
      frame_active = 1'b0;
      #(4 * HALF);
      check({name, " strobes"}, strobe_cnt - s0, exp_strobe);
      check({name, " frame_err"}, ferr_cnt - f0, exp_ferr);
      if (exp_strobe != 0) check({name, " sampled_ch"}, int'(sampled_ch), exp_ch);
      if (dstart > 0) begin
         for (int i = 0; i < 10; i++) rx[9-i] = rx_bits[dstart+i][0];
         check({name, " word"}, int'(rx), int'(lit));
      end
   endtask

   initial begin
      adc_cs       = 1'(($urandom));
      adc_sck      = 1'(($urandom));
      sdata_to_adc = 1'(($urandom));
      ch0_data     = 10'($urandom);
      ch1_data     = 10'($urandom);
      #55;
      check("rst sdo", int'(sdata_from_adc), 0);
      check("rst oe", int'(sdo_oe), 0);
      check("rst strobe", int'(sample_strobe), 0);
      check("rst ch", int'(sampled_ch), 0);
      check("rst ferr", int'(frame_err), 0);
      adc_cs = 1'b1;
      adc_sck = 1'b0;
      sdata_to_adc = 1'b0;
      #40;
      rst_n = 1'b1;
      #400;
      check("idle oe", int'(sdo_oe), 0);
      check("idle sdo", int'(sdata_from_adc), 0);
      check("idle pulses", strobe_cnt + ferr_cnt, 0);

      run_frame("se ch1",    32'h3C, 16, 0, 10'h000, 10'h2A5, 0, 10'h000, 7, 10'h2A5);
      run_frame("diff 0",    32'h24, 16, 0, 10'd300, 10'd100, 0, 10'h000, 7, 10'd200);
      run_frame("diff 1",    32'h34, 16, 0, 10'd300, 10'd100, 0, 10'h000, 7, 10'd0);
      run_frame("b2b ff",    32'h2C, 16, 0, 10'h3FF, 10'h000, 0, 10'h000, 7, 10'h3FF);
      run_frame("b2b 00",    32'h2C, 16, 0, 10'h000, 10'h3FF, 0, 10'h000, 7, 10'h000);
      run_frame("midchg",    32'h2C, 16, 0, 10'h3FF, 10'h000, 8, 10'h000, 7, 10'h3FF);
      run_frame("abort",     32'h3C, 16, 9, 10'h000, 10'h2A5, 0, 10'h000, 0, 10'h000);
      run_frame("post abt",  32'h3C, 16, 0, 10'h000, 10'h155, 0, 10'h000, 7, 10'h155);
      run_frame("lead0 x20", 32'hB0, 20, 0, 10'h1C3, 10'h2A5, 0, 10'h000, 9, 10'h1C3);
      run_frame("nostart",   32'h00,  8, 0, 10'h3FF, 10'h3FF, 0, 10'h000, 0, 10'h000);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
